// File: rtl/pueo_cmdproc_pkg.sv
// Shared types for the TURFIO command-processor packet buffer.
//   wr_state_e      : packet-writer states (IDLE / FILL / DROP)
//   cmdproc_entry_t : one stored buffer entry, {last, data}
//   MAX_PKT_DEFAULT : default maximum accepted packet length in bytes
package pueo_cmdproc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DROP = 2'd2
    } wr_state_e;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } cmdproc_entry_t;

    localparam int MAX_PKT_DEFAULT = 64;

endpackage

// File: rtl/cmdproc_buf_ram.sv
// Simple dual-port RAM for the command packet buffer.
//   clk_i      : single clock for both ports
//   wr_en_i    : write strobe; wr_addr_i / wr_data_i written at the edge
//   rd_en_i    : read strobe; rd_data_o updates only when asserted, so a
//                stalled read holds its value
//   rd_addr_i  : read address
//   rd_data_o  : registered read data (one cycle after rd_en_i)
module cmdproc_buf_ram
    import pueo_cmdproc_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [DEPTH_LOG2-1:0] wr_addr_i,
    input  cmdproc_entry_t        wr_data_i,
    input  logic                  rd_en_i,
    input  logic [DEPTH_LOG2-1:0] rd_addr_i,
    output cmdproc_entry_t        rd_data_o
);

    cmdproc_entry_t mem [2**DEPTH_LOG2];
    cmdproc_entry_t rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_q <= mem[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/turfio_cmdproc_buffer.sv
// Packet buffer behind the TURF command decoder. Stores only complete
// packets from the unbackpressured decoder stream, drops oversized or
// overflowing packets whole, and replays committed packets on a
// backpressured byte stream.
//   sysclk_i, rst_i             : clock, synchronous active-high reset
//   cmdproc_rst_i               : abort, discards the packet in progress
//   cmdproc_tdata/tvalid/tlast_i: input byte stream (no ready)
//   m_tdata/tvalid/tlast_o, m_tready_i : output byte stream
//   pkt_count_o                 : complete packets held
//   drop_count_o                : dropped packets, saturating
//   overflow_o                  : one-cycle pulse per dropped packet
//
// Write FSM
//   state   | meaning
//   IDLE    | between packets, next valid byte starts a packet
//   FILL    | packet in progress, bytes written tentatively
//   DROP    | packet rejected, discarding bytes until tlast
module turfio_cmdproc_buffer
    import pueo_cmdproc_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int MAX_PKT    = MAX_PKT_DEFAULT
) (
    input  logic                  sysclk_i,
    input  logic                  rst_i,
    input  logic                  cmdproc_rst_i,
    input  logic [7:0]            cmdproc_tdata_i,
    input  logic                  cmdproc_tvalid_i,
    input  logic                  cmdproc_tlast_i,
    output logic [7:0]            m_tdata_o,
    output logic                  m_tvalid_o,
    input  logic                  m_tready_i,
    output logic                  m_tlast_o,
    output logic [DEPTH_LOG2-1:0] pkt_count_o,
    output logic [15:0]           drop_count_o,
    output logic                  overflow_o
);

    localparam int LEN_W = $clog2(MAX_PKT + 1);
    typedef logic [DEPTH_LOG2-1:0] ptr_t;

    wr_state_e      state_q, state_d;
    ptr_t           wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
    ptr_t           rd_ptr_q, rd_ptr_d, fetch_ptr_q, fetch_ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    ptr_t           pkt_count_q, pkt_count_d;
    logic [15:0]    drop_count_q, drop_count_d;
    logic           overflow_q, overflow_d;
    logic           a_vld_q, a_vld_d, b_vld_q, b_vld_d;
    cmdproc_entry_t b_data_q, b_data_d;

    logic           ram_wr_en, ram_rd_en;
    cmdproc_entry_t ram_wr_data, ram_rd_data, pres;
    logic           full, commit, drop, xfer, a_free;

    assign ram_wr_data = {cmdproc_tlast_i, cmdproc_tdata_i};

    cmdproc_buf_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk_i     (sysclk_i),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (ram_wr_data),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (fetch_ptr_q),
        .rd_data_o (ram_rd_data)
    );

    // Two read stages: A is the RAM read register, B the output register.
    // The presented entry is B when it holds data, otherwise A, which lets
    // a freshly committed byte appear one edge after commit.
    assign pres       = b_vld_q ? b_data_q : ram_rd_data;
    assign m_tvalid_o = a_vld_q | b_vld_q;
    assign m_tdata_o  = m_tvalid_o ? pres.data : 8'h00;
    assign m_tlast_o  = m_tvalid_o & pres.last;
    assign xfer       = m_tvalid_o & m_tready_i;

    assign pkt_count_o  = pkt_count_q;
    assign drop_count_o = drop_count_q;
    assign overflow_o   = overflow_q;

    // Write side
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        len_d        = len_q;
        ram_wr_en    = 1'b0;
        commit       = 1'b0;
        drop         = 1'b0;
        // Space is freed by transfers (rd_ptr), not by prefetch, so
        // entries sitting in A/B are never overwritten.
        full         = (wr_ptr_q + ptr_t'(1)) == rd_ptr_q;

        if (cmdproc_rst_i) begin
            wr_ptr_d = commit_ptr_q;
            state_d  = ST_IDLE;
        end else if (cmdproc_tvalid_i) begin
            unique case (state_q)
                ST_IDLE, ST_FILL: begin
                    if (full || (state_q == ST_FILL && len_q == LEN_W'(MAX_PKT))) begin
                        drop     = 1'b1;
                        wr_ptr_d = commit_ptr_q;
                        state_d  = cmdproc_tlast_i ? ST_IDLE : ST_DROP;
                    end else begin
                        ram_wr_en = 1'b1;
                        wr_ptr_d  = wr_ptr_q + ptr_t'(1);
                        len_d     = (state_q == ST_IDLE) ? LEN_W'(1) : len_q + LEN_W'(1);
                        if (cmdproc_tlast_i) begin
                            commit       = 1'b1;
                            commit_ptr_d = wr_ptr_q + ptr_t'(1);
                            state_d      = ST_IDLE;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end
                end
                ST_DROP: if (cmdproc_tlast_i) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Read side and counters
    always_comb begin
        // A can accept a new read if empty, or if its entry moves to B or
        // leaves through the output this cycle.
        a_free      = !a_vld_q || !b_vld_q || xfer;
        ram_rd_en   = (fetch_ptr_q != commit_ptr_q) && a_free;
        fetch_ptr_d = ram_rd_en ? fetch_ptr_q + ptr_t'(1) : fetch_ptr_q;
        rd_ptr_d    = xfer ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
        a_vld_d     = ram_rd_en || (a_vld_q && !a_free);

        b_data_d = b_data_q;
        if (b_vld_q) b_vld_d = xfer ? a_vld_q : 1'b1;
        else         b_vld_d = a_vld_q && !xfer;
        if (a_vld_q && (b_vld_q ? xfer : !xfer)) b_data_d = ram_rd_data;

        pkt_count_d = pkt_count_q;
        unique case ({commit, xfer && pres.last})
            2'b10:   pkt_count_d = pkt_count_q + ptr_t'(1);
            2'b01:   pkt_count_d = pkt_count_q - ptr_t'(1);
            default: pkt_count_d = pkt_count_q;
        endcase

        drop_count_d = drop_count_q;
        if (drop && drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
        overflow_d = drop;
    end

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            fetch_ptr_q  <= '0;
            len_q        <= '0;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
            a_vld_q      <= 1'b0;
            b_vld_q      <= 1'b0;
            b_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fetch_ptr_q  <= fetch_ptr_d;
            len_q        <= len_d;
            pkt_count_q  <= pkt_count_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
            a_vld_q      <= a_vld_d;
            b_vld_q      <= b_vld_d;
            b_data_q     <= b_data_d;
        end
    end

endmodule
